instruction_fetch: RTL
======================

# instruction_fetch

IF stage of the 5-stage pipeline. Holds the program counter and a word-addressed instruction memory, and fetches one 32-bit instruction per cycle into the IF/ID pipeline register. It drives `instruction_s1` and `pc_out1_s1` directly into the decode stage, which captures them on the next edge. It accepts stall, flush and taken-branch redirect from downstream stages, and has a write port for loading programs.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two. `AW = log2(IMEM_DEPTH)`.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset; word aligned.
- `BUBBLE`, 32'hFC00_0000: instruction injected on squash. Opcode 6'b111111 decodes to the default control case, which has RegWrite=0, MemWrite=0 and Branch=0.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `reset`  in  1  asynchronous, active-high reset.
  - `stall`  in  1  hold PC and the IF/ID register.
  - `flush`  in  1  squash the IF/ID register and refetch at the current PC.
  - `branch_taken`  in  1  redirect PC to `branch_target`.
  - `branch_target`  in  32  byte address of the redirect; bits [1:0] are ignored and treated as 0.
  - `imem_we`  in  1  instruction memory write enable.
  - `imem_waddr`  in  AW  word index to write.
  - `imem_wdata`  in  32  word to write.
  - `pc_current`  out  32  current PC; combinational view of the PC register.
  - `instruction_s1`  out  32  IF/ID instruction.
  - `pc_out1_s1`  out  32  IF/ID PC+4.
  - `valid_s1`  out  1  the IF/ID register holds a real (non-bubble) instruction.
  - `fetch_count`  out  32  number of instructions delivered valid since reset.

## Operation
- **Memory read.** Asynchronous read of `imem[pc[AW+1:2]]`. PC bits above AW+1 are ignored, so addresses wrap modulo `IMEM_DEPTH` words.
- **Memory write.** Synchronous on `clk` when `imem_we` is high.
  - The write works independently of `reset` and `stall`.
  - The contents are not cleared by reset.
  - Read-during-write at the same index: the fetch on that edge captures the old word.
- **Per-edge priority** (highest first):
  1. `reset` asserted: PC=`RESET_PC`, `instruction_s1`=`BUBBLE`, `pc_out1_s1`=0, `valid_s1`=0, `fetch_count`=0. Takes effect asynchronously.
  2. `branch_taken`: PC <= {`branch_target`[31:2],2'b00}; IF/ID <= `BUBBLE`, `valid_s1` <= 0, `pc_out1_s1` <= 0. This applies regardless of `stall` and `flush`.
  3. `flush`: PC holds; IF/ID <= `BUBBLE`, `valid_s1` <= 0, `pc_out1_s1` <= 0. This applies regardless of `stall`.
  4. `stall`: PC, `instruction_s1`, `pc_out1_s1` and `valid_s1` all hold.
  5. Normal: `instruction_s1` <= imem[PC]; `pc_out1_s1` <= PC+4; `valid_s1` <= 1; PC <= PC+4.
- **PC arithmetic.** 32-bit, modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Memory indexing wraps as described above.
- **`fetch_count`.** Increments by 1 on each normal-case edge only; it wraps at 2^32.

## Timing
- Fetch latency is one cycle. If PC=p before edge k, then after edge k `instruction_s1`=imem[p], `pc_out1_s1`=p+4, PC=p+4.
- Taken-branch penalty from this stage is one bubble. The edge with `branch_taken` high loads the bubble; the next edge delivers imem[target].
- Stall of N cycles: the outputs are frozen for N edges. The next normal edge then delivers the instruction at the held PC; no instruction is lost or duplicated.
- Flush penalty is one bubble. The instruction at the held PC is delivered on the following normal edge.
- `stall`, `flush` and `branch_taken` are sampled only at rising edges and may change freely between edges.
- Reset asserted mid-stream clears the outputs immediately, without waiting for a clock edge. On the first edge after deassertion (if no stall/flush/branch), imem[`RESET_PC`] is fetched.
- `pc_current` reflects the PC register with no extra delay.

## Test plan
- **Reset then run.** Load words 0..3 = 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444. Release reset and clock 4 edges. Required:
  - `instruction_s1` = 1111, 2222, 3333, 4444 on successive edges.
  - `pc_out1_s1` = 4, 8, 12, 16.
  - `fetch_count`=4.
- **Stall.** With PC=8, hold `stall` for 3 edges. Required:
  - `instruction_s1`=2222, `pc_out1_s1`=8 and `pc_current`=8 held for all 3 edges.
  - The next edge delivers 3333, with `pc_out1_s1`=12.
  - `fetch_count` does not change during the stall.
- **Taken branch during stall.** Assert `branch_taken`=1 with `branch_target`=32'h0000_0007 while `stall`=1. Required:
  - After that edge: PC=4, `instruction_s1`=FC00_0000, `valid_s1`=0.
  - The next edge delivers 2222 with `pc_out1_s1`=8.
- **Flush.** Assert `flush` at PC=12. Required:
  - After that edge: a bubble in IF/ID and PC=12.
  - The next edge delivers 4444 with `pc_out1_s1`=16.
- **Wrap and read-during-write.** With `IMEM_DEPTH`=64 and PC=32'h0000_0100, expect imem[0] to be fetched. At PC=0, write word 0 = 32'hAAAA_AAAA on the same edge. Required:
  - That edge captures the old word.
  - A later fetch of index 0 returns AAAA_AAAA.
- **Async reset mid-run.** Pulse `reset` between edges. Required:
  - All outputs immediately take their reset values.
  - Memory contents are preserved.
  - After release, the first edge delivers imem[`RESET_PC`].

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: program counter, word-addressed instruction memory and the IF/ID register.
// Redirects from branch, flush and stall arrive from later stages and are resolved at each rising edge.
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] BUBBLE     = 32'hFC00_0000,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   pc_current,
    output logic [31:0]   instruction_s1,
    output logic [31:0]   pc_out1_s1,
    output logic          valid_s1,
    output logic [31:0]   fetch_count
);

    logic [31:0] imem_q [IMEM_DEPTH];
    logic [31:0] fetch_word;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] fcnt_q, fcnt_d;

    // NOTE: the memory has no reset so a program loaded before/while reset is held survives it.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    // Upper PC bits are dropped, so fetch addresses wrap modulo IMEM_DEPTH words.
    assign fetch_word = imem_q[pc_q[AW+1:2]];

    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        fcnt_d   = fcnt_q;
        if (branch_taken) begin
            pc_d     = branch_target & ~32'h0000_0003;
            instr_d  = BUBBLE;
            pc_out_d = '0;
            valid_d  = 1'b0;
        end else if (flush) begin
            instr_d  = BUBBLE;
            pc_out_d = '0;
            valid_d  = 1'b0;
        end else if (!stall) begin
            instr_d  = fetch_word;
            pc_out_d = pc_q + 32'd4;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            fcnt_d   = fcnt_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= BUBBLE;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign pc_current     = pc_q;
    assign instruction_s1 = instr_q;
    assign pc_out1_s1     = pc_out_q;
    assign valid_s1       = valid_q;
    assign fetch_count    = fcnt_q;

endmodule
